candy_div: RTL
==============

# candy_div

Iterative 24-bit integer divider for the candy CPU execute stage. It is the responder side of the ALU's divide interface: the ALU holds a start request with operands and stalls the pipeline until this block raises ready with a quotient and remainder. The block computes one quotient bit per cycle using restoring division and supports signed and unsigned modes. Divide-by-zero takes a short path.

## Interface
- `WIDTH`, 24: operand, quotient and remainder width (matches `RegBus`).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `signed_div_i`  in  1: 1 = signed (two's complement) divide, 0 = unsigned. Sampled with `start_i` in FREE.
- `opdata1_i`  in  WIDTH: dividend. Sampled in FREE.
- `opdata2_i`  in  WIDTH: divisor. Sampled in FREE.
- `start_i`  in  1: request. Held high by the ALU until it has consumed the result.
- `annul_i`  in  1: abort (pipeline flush). Overrides everything except reset.
- `quotient_o`  out  WIDTH: quotient, registered.
- `remainder_o`  out  WIDTH: remainder, registered.
- `ready_o`  out  1: result valid, registered.

## Operation
- State register: FREE, DIVZERO, ON, END. Reset state is FREE.
- Reset values: `ready_o`=0, `quotient_o`=0, `remainder_o`=0. The counter and all working registers reset to 0.
- FREE:
  - If `start_i`=1 and `annul_i`=0, latch the operands and mode.
  - If divisor is 0, go to DIVZERO.
  - Otherwise load the dividend magnitude into the working register, clear the partial remainder and counter, and go to ON.
- Signed mode, operand conversion: a negative operand is replaced by its two's-complement negation. The magnitude is treated as WIDTH-bit unsigned, so -2^23 gives 0x800000.
- ON, each cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor magnitude using a WIDTH+1-bit subtract.
  - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise keep the old value and shift in 0.
  - Increment the counter.
  - On the iteration where the counter reaches WIDTH-1, write the corrected results to the outputs, set `ready_o`=1 and go to END.
- Sign correction (signed mode only):
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Quotient is truncated to WIDTH bits, so -2^23 / -1 gives 0x800000 with remainder 0.
- DIVZERO: next cycle writes `quotient_o`=all ones and `remainder_o`=dividend (unmodified), sets `ready_o`=1 and goes to END. This is identical in both modes.
- END:
  - Outputs hold while `start_i`=1.
  - When `start_i`=0, go to FREE and clear `ready_o` to 0 on that edge. `quotient_o` and `remainder_o` keep their values.
- Abort:
  - In ON or DIVZERO, `annul_i`=1 or `start_i`=0 on a clock edge returns the block to FREE.
  - `ready_o` stays 0 and the outputs are not updated.
  - In END, `annul_i`=1 returns to FREE and clears `ready_o`.
- A new request is accepted only from FREE. An edge in END never restarts the divider, even if `start_i` stays high.
- Asynchronous reset at any point forces FREE and the reset values immediately.

## Timing
- Call the edge that samples `start_i`=1 in FREE edge E0.
- Normal divide: iterations run on edges E1..E24 (WIDTH edges). `ready_o`=1 and results are valid after edge E24, i.e. 24 cycles after E0 and 25 cycles after `start_i` rises.
- Divide by zero: `ready_o`=1 after edge E1.
- The ALU drops `start_i` in the cycle after it sees `ready_o`=1. `ready_o` falls on the following edge, and FREE accepts a new request on the edge after that.
- No combinational path from inputs to outputs.

## Configuration
- `CANDY_DIV_SIGNED_EN` defined:
  - `signed_div_i` is honoured.
  - Operand negation and result sign correction are built in.
- Not defined:
  - `signed_div_i` is ignored; every divide is unsigned.
  - The negation and correction logic is removed.
  - Latency and handshake are unchanged.

## Test plan
- Unsigned 100 / 7, hold start → `ready_o` rises exactly 24 cycles after E0 with q=0x00000E, r=0x000002; drop start → `ready_o`=0 next edge, state FREE.
- Signed 0xFFFFF9 (-7) / 2 → q=0xFFFFFD (-3), r=0xFFFFFF (-1). With the macro undefined, same stimulus → q=0x7FFFFC, r=0x000001.
- Signed 0x800000 / 0xFFFFFF (-1) → q=0x800000, r=0x000000. Unsigned 0xFFFFFF / 0x000001 → q=0xFFFFFF, r=0.
- 5 / 0 in either mode → `ready_o`=1 after E1 with q=0xFFFFFF, r=0x000005.
- Pulse `annul_i` at cycle 10 of a divide → `ready_o` never rises, block in FREE. A new 9 / 3 request then gives q=3, r=0 at normal latency.
- Assert `rst`=0 mid-divide, and separately while in END → all outputs 0 immediately, FREE after release. Holding `start_i` through END for 5 extra cycles → outputs stable and no restart.

Source files
------------

// File: rtl/candy_div.sv
// candy_div: iterative restoring divider, one quotient bit per cycle, start/ready handshake.
// Define CANDY_DIV_SIGNED_EN to honour signed_div_i (operand negation and sign correction).
module candy_div #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signed_div_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  input  logic             start_i,
  input  logic             annul_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             ready_o
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {FREE, DIVZERO, ON, END} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
  logic             rdy_q, rdy_d;
  logic [WIDTH-1:0] a_mag, b_mag, rem_n, dvd_n, q_fix, r_fix;
  logic [WIDTH:0]   trial;
`ifdef CANDY_DIV_SIGNED_EN
  logic qneg_q, qneg_d, rneg_q, rneg_d, a_neg, b_neg;
  always_comb begin
    a_neg = signed_div_i & opdata1_i[WIDTH-1];
    b_neg = signed_div_i & opdata2_i[WIDTH-1];
    a_mag = a_neg ? -opdata1_i : opdata1_i;
    b_mag = b_neg ? -opdata2_i : opdata2_i;
    q_fix = qneg_q ? -dvd_n : dvd_n;
    r_fix = rneg_q ? -rem_n : rem_n;
    qneg_d = (state_q == FREE) ? a_neg ^ b_neg : qneg_q;
    rneg_d = (state_q == FREE) ? a_neg : rneg_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) {qneg_q, rneg_q} <= '0;
    else {qneg_q, rneg_q} <= {qneg_d, rneg_d};
`else
  logic unused_signed;
  assign unused_signed = signed_div_i;
  assign a_mag = opdata1_i;
  assign b_mag = opdata2_i;
  assign q_fix = dvd_n;
  assign r_fix = rem_n;
`endif
  // Partial remainder is widened by one bit so the shifted-out MSB is never lost.
  always_comb begin
    trial = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
    rem_n = trial[WIDTH] ? {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]} : trial[WIDTH-1:0];
    dvd_n = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    rdy_d   = rdy_q;
    case (state_q)
      FREE: if (start_i && !annul_i) begin
        state_d = (opdata2_i == '0) ? DIVZERO : ON;
        dvd_d   = (opdata2_i == '0) ? opdata1_i : a_mag;
        dvs_d   = b_mag;
        rem_d   = '0;
        cnt_d   = '0;
      end
      DIVZERO: begin
        state_d = (annul_i || !start_i) ? FREE : END;
        quo_d   = (annul_i || !start_i) ? quo_q : '1;
        rmd_d   = (annul_i || !start_i) ? rmd_q : dvd_q;
        rdy_d   = !(annul_i || !start_i);
      end
      ON: if (annul_i || !start_i) state_d = FREE;
      else begin
        rem_d = rem_n;
        dvd_d = dvd_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          quo_d   = q_fix;
          rmd_d   = r_fix;
          rdy_d   = 1'b1;
          state_d = END;
        end
      end
      default: if (annul_i || !start_i) begin
        state_d = FREE;
        rdy_d   = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= FREE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      rdy_q   <= rdy_d;
    end
  assign quotient_o  = quo_q;
  assign remainder_o = rmd_q;
  assign ready_o     = rdy_q;
endmodule
